// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the request/grant handshake between the fetch control unit (fcu),
// the execution unit (eu), the bus interface unit (biu) and the arbiter.
//   master modport : requester/biu side (drives req_*, sel_*, ready_bus)
//   slave  modport : arbiter side (drives grants, chip select, pulses, busy)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface bus_arbiter_if;
    logic       req_fcu;
    logic       req_eu;
    logic [1:0] sel_fcu;
    logic [1:0] sel_eu;
    logic       ready_bus;
    logic       gnt_fcu;
    logic       gnt_eu;
    logic       cs_biu;
    logic [1:0] sel_biu;
    logic       done_fcu;
    logic       done_eu;
    logic       timeout;
    logic       busy;

    modport master (
        output req_fcu, req_eu, sel_fcu, sel_eu, ready_bus,
        input  gnt_fcu, gnt_eu, cs_biu, sel_biu, done_fcu, done_eu, timeout, busy
    );

    modport slave (
        input  req_fcu, req_eu, sel_fcu, sel_eu, ready_bus,
        output gnt_fcu, gnt_eu, cs_biu, sel_biu, done_fcu, done_eu, timeout, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Arbitrates the single biu between the fetch control unit and the execution
// unit. A grant lasts until ready_bus, a hold-limit timeout, or the owner
// dropping its request; every grant is followed by one TURN cycle with the
// bus deselected.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   bus        : bus_arbiter_if.slave (requests, selects, ready_bus in;
//                grants, cs_biu, sel_biu, done/timeout pulses, busy out)
//
// Parameters
//   MAX_HOLD   : grant cycles allowed without ready_bus (1..15)
//   STARVE_LIM : consecutive lost arbitrations before fcu is forced (1..7)
//
// Configuration macro
//   BUS_ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//                            (round robin) and the starvation counter is
//                            removed; default build uses eu priority with
//                            fcu starvation protection.
//
// done_fcu/done_eu/timeout are decoded from the registered grant state and
// the live ready_bus/req inputs so they land in the same cycle as the event
// that ends the grant; all other outputs come straight from flops.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int MAX_HOLD   = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_FCU = 2'b01,
        GNT_EU  = 2'b10,
        TURN    = 2'b11
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t     state_r;
    logic       gnt_fcu_r;
    logic       gnt_eu_r;
    logic       cs_biu_r;
    logic [1:0] sel_biu_r;
    logic       busy_r;
    logic [3:0] hold_r;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic       prio_eu_r;   // 1: eu wins the next tie
`else
    localparam logic [2:0] STARVE_C = 3'(STARVE_LIM);
    logic [2:0] starve_r;
`endif

    logic in_grant_s;
    logic req_own_s;
    logic abort_s;
    logic done_s;
    logic limit_s;
    logic any_req_s;
    logic fcu_wins_s;

    assign in_grant_s = (state_r == GNT_FCU) || (state_r == GNT_EU);
    assign req_own_s  = (state_r == GNT_FCU) ? bus.req_fcu : bus.req_eu;
    // Owner dropping its request ends the grant silently and outranks both
    // ready_bus and the hold limit; ready_bus outranks the hold limit.
    assign abort_s    = in_grant_s && !req_own_s;
    assign done_s     = in_grant_s && req_own_s && bus.ready_bus;
    assign limit_s    = in_grant_s && req_own_s && !bus.ready_bus &&
                        ((hold_r + 4'd1) == HOLD_LIM);
    assign any_req_s  = bus.req_fcu || bus.req_eu;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign fcu_wins_s = bus.req_fcu && (!bus.req_eu || !prio_eu_r);
`else
    assign fcu_wins_s = bus.req_fcu && (!bus.req_eu || (starve_r == STARVE_C));
`endif

    assign bus.gnt_fcu  = gnt_fcu_r;
    assign bus.gnt_eu   = gnt_eu_r;
    assign bus.cs_biu   = cs_biu_r;
    assign bus.sel_biu  = sel_biu_r;
    assign bus.busy     = busy_r;
    assign bus.done_fcu = done_s && (state_r == GNT_FCU);
    assign bus.done_eu  = done_s && (state_r == GNT_EU);
    assign bus.timeout  = limit_s;

    // Arbitration FSM with registered grant, chip-select, select and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            gnt_fcu_r <= 1'b0;
            gnt_eu_r  <= 1'b0;
            cs_biu_r  <= 1'b0;
            sel_biu_r <= 2'b00;
            busy_r    <= 1'b0;
            hold_r    <= 4'd0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            prio_eu_r <= 1'b1;
`else
            starve_r  <= 3'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    hold_r <= 4'd0;
                    if (any_req_s) begin
                        cs_biu_r <= 1'b1;
                        busy_r   <= 1'b1;
                        if (fcu_wins_s) begin
                            state_r   <= GNT_FCU;
                            gnt_fcu_r <= 1'b1;
                            gnt_eu_r  <= 1'b0;
                            sel_biu_r <= bus.sel_fcu;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                            prio_eu_r <= 1'b1;
`else
                            starve_r  <= 3'd0;
`endif
                        end else begin
                            state_r   <= GNT_EU;
                            gnt_fcu_r <= 1'b0;
                            gnt_eu_r  <= 1'b1;
                            sel_biu_r <= bus.sel_eu;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                            prio_eu_r <= 1'b0;
`else
                            // fcu lost a contested decision
                            if (bus.req_fcu) begin
                                starve_r <= starve_r + 3'd1;
                            end else begin
                                starve_r <= starve_r;
                            end
`endif
                        end
                    end else begin
                        state_r   <= IDLE;
                        gnt_fcu_r <= 1'b0;
                        gnt_eu_r  <= 1'b0;
                        cs_biu_r  <= 1'b0;
                        sel_biu_r <= 2'b00;
                        busy_r    <= 1'b0;
                    end
                end
                GNT_FCU, GNT_EU: begin
                    if (abort_s || done_s || limit_s) begin
                        state_r   <= TURN;
                        gnt_fcu_r <= 1'b0;
                        gnt_eu_r  <= 1'b0;
                        cs_biu_r  <= 1'b0;
                        sel_biu_r <= 2'b00;
                        hold_r    <= 4'd0;
                    end else begin
                        hold_r    <= hold_r + 4'd1;
                    end
                end
                TURN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    gnt_fcu_r <= 1'b0;
                    gnt_eu_r  <= 1'b0;
                    cs_biu_r  <= 1'b0;
                    sel_biu_r <= 2'b00;
                    busy_r    <= 1'b0;
                    hold_r    <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Randomized transactions are pushed into a scoreboard with the expected
// winner, select, ending kind and grant length taken from a behavioural
// arbitration model; an independent monitor pops and checks each grant.
// Directed phases cover reset mid-grant and continuous contention.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int MAX_HOLD   = 15;
    localparam int STARVE_LIM = 4;
    localparam int K_DONE     = 0;
    localparam int K_TIMEOUT  = 1;
    localparam int K_ABORT    = 2;

    typedef struct {
        logic       fcu;
        logic [1:0] sel;
        int         kind;
        int         len;
        int         req_cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    bus_arbiter_if bus_if();

    bus_arbiter #(.MAX_HOLD(MAX_HOLD), .STARVE_LIM(STARVE_LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    exp_t sb_q[$];
    bit   mon_en   = 1'b0;

    // model state: fcu losses in a row / who was granted last
    int   fcu_losses   = 0;
    logic last_was_fcu = 1'b1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cycle);
    endtask

    function automatic void model_reset();
        fcu_losses   = 0;
        last_was_fcu = 1'b1;
    endfunction

    // Returns 1 when fcu should win a decision with the given requests.
    function automatic logic model_pick(input logic rf, input logic re);
        logic f;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        f = rf && (!re || !last_was_fcu);
        last_was_fcu = f;
`else
        f = rf && (!re || (fcu_losses == STARVE_LIM));
        if (f) fcu_losses = 0;
        else if (rf) fcu_losses++;
`endif
        return f;
    endfunction

    task automatic drive_idle();
        bus_if.req_fcu   = 1'b0;
        bus_if.req_eu    = 1'b0;
        bus_if.sel_fcu   = 2'b00;
        bus_if.sel_eu    = 2'b00;
        bus_if.ready_bus = 1'b0;
    endtask

    task automatic wait_idle(input bit noise);
        int w;
        w = 0;
        while (bus_if.busy && w < 40) begin
            if (noise) bus_if.ready_bus = 1'($urandom_range(0, 1));
            @(negedge clk);
            w++;
        end
        if (bus_if.busy) fail_now("idle_wait");
        bus_if.ready_bus = 1'b0;
    endtask

    task automatic run_txn();
        logic       rf, re, win;
        logic [1:0] sf, se;
        int         pat, mode, r, a, n, w;
        exp_t       e;
        pat = $urandom_range(0, 2);
        rf  = (pat != 1);
        re  = (pat != 0);
        sf  = 2'($urandom_range(0, 3));
        se  = 2'($urandom_range(0, 3));
        mode = $urandom_range(0, 6);
        r = 0;
        a = 0;
        case (mode)
            0:       a = $urandom_range(1, 4);
            1:       r = MAX_HOLD;
            2:       r = MAX_HOLD + 2;
            default: r = $urandom_range(1, 6);
        endcase
        win         = model_pick(rf, re);
        e.fcu       = win;
        e.sel       = win ? sf : se;
        e.req_cycle = cycle;
        if (a != 0) begin
            e.kind = K_ABORT;   e.len = a;
        end else if (r <= MAX_HOLD) begin
            e.kind = K_DONE;    e.len = r;
        end else begin
            e.kind = K_TIMEOUT; e.len = MAX_HOLD;
        end
        sb_q.push_back(e);
        bus_if.sel_fcu   = sf;
        bus_if.sel_eu    = se;
        bus_if.req_fcu   = rf;
        bus_if.req_eu    = re;
        bus_if.ready_bus = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(bus_if.gnt_fcu || bus_if.gnt_eu) && w < 4);
        if (!(bus_if.gnt_fcu || bus_if.gnt_eu)) begin
            fail_now("grant_wait");
            drive_idle();
            wait_idle(1'b0);
            return;
        end
        n = 1;
        while ((bus_if.gnt_fcu || bus_if.gnt_eu) && n <= MAX_HOLD + 2) begin
            if (bus_if.gnt_fcu) begin
                bus_if.req_eu  = 1'b0;
                bus_if.req_fcu = !(a != 0 && n >= a);
            end else begin
                bus_if.req_fcu = 1'b0;
                bus_if.req_eu  = !(a != 0 && n >= a);
            end
            bus_if.ready_bus = (n == r);
            bus_if.sel_fcu   = 2'($urandom_range(0, 3));
            bus_if.sel_eu    = 2'($urandom_range(0, 3));
            @(negedge clk);
            n++;
        end
        if (bus_if.gnt_fcu || bus_if.gnt_eu) fail_now("grant_release");
        bus_if.req_fcu = 1'b0;
        bus_if.req_eu  = 1'b0;
        wait_idle(1'b1);
        repeat ($urandom_range(0, 2)) begin
            bus_if.ready_bus = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus_if.ready_bus = 1'b0;
    endtask

    // Scoreboard monitor: samples just after the falling edge.
    initial begin
        exp_t cur;
        bit   in_g, chk_idle;
        int   glen, dones, touts;
        logic g;
        in_g = 1'b0; chk_idle = 1'b0; glen = 0; dones = 0; touts = 0;
        cur = '{1'b0, 2'b00, 0, 0, 0};
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && reset) begin
                g = bus_if.gnt_fcu | bus_if.gnt_eu;
                check("gnt_mutex", bus_if.gnt_fcu & bus_if.gnt_eu, 1'b0);
                check("cs_matches_gnt", bus_if.cs_biu, g);
                check("done_fcu_gated", bus_if.done_fcu & ~bus_if.gnt_fcu, 1'b0);
                check("done_eu_gated", bus_if.done_eu & ~bus_if.gnt_eu, 1'b0);
                check("timeout_gated", bus_if.timeout & ~g, 1'b0);
                if (!g) check("sel_outside_grant", bus_if.sel_biu, 2'b00);
                if (chk_idle) begin
                    check("turn_one_cycle", bus_if.busy, 1'b0);
                    chk_idle = 1'b0;
                end
                if (g && !in_g) begin
                    if (sb_q.size() == 0) begin
                        fail_now("scoreboard_empty");
                    end else begin
                        cur = sb_q.pop_front();
                    end
                    in_g = 1'b1; glen = 0; dones = 0; touts = 0;
                    check("grant_latency", cycle - cur.req_cycle, 1);
                    check("winner_fcu", bus_if.gnt_fcu, cur.fcu);
                end
                if (g) begin
                    glen++;
                    check("sel_biu_held", bus_if.sel_biu, cur.sel);
                    dones += int'(bus_if.done_fcu | bus_if.done_eu);
                    touts += int'(bus_if.timeout);
                end else if (in_g) begin
                    in_g = 1'b0;
                    check("grant_len", glen, cur.len);
                    check("done_count", dones, (cur.kind == K_DONE) ? 1 : 0);
                    check("timeout_count", touts, (cur.kind == K_TIMEOUT) ? 1 : 0);
                    check("turn_busy", bus_if.busy, 1'b1);
                    chk_idle = 1'b1;
                end
            end
        end
    end

    task automatic reset_mid_grant();
        drive_idle();
        wait_idle(1'b0);
        bus_if.req_eu = 1'b1;
        bus_if.sel_eu = 2'b11;
        void'(model_pick(1'b0, 1'b1));
        @(negedge clk);
        check("rst_test_gnt1", bus_if.gnt_eu, 1'b1);
        @(negedge clk);
        check("rst_test_gnt2", bus_if.gnt_eu, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        check("async_gnt_eu", bus_if.gnt_eu, 1'b0);
        check("async_cs", bus_if.cs_biu, 1'b0);
        check("async_sel", bus_if.sel_biu, 2'b00);
        check("async_busy", bus_if.busy, 1'b0);
        check("async_done", bus_if.done_eu | bus_if.done_fcu, 1'b0);
        check("async_timeout", bus_if.timeout, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        void'(model_pick(1'b0, 1'b1));
        @(negedge clk);
        check("regrant_gnt_eu", bus_if.gnt_eu, 1'b1);
        check("regrant_cs", bus_if.cs_biu, 1'b1);
        check("regrant_sel", bus_if.sel_biu, 2'b11);
        bus_if.ready_bus = 1'b1;
        #1;
        check("regrant_done", bus_if.done_eu, 1'b1);
        @(negedge clk);
        drive_idle();
        check("regrant_released", bus_if.cs_biu, 1'b0);
        wait_idle(1'b0);
    endtask

    task automatic continuous_phase();
        logic exp_f;
        int   w;
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_if.req_fcu   = 1'b1;
        bus_if.req_eu    = 1'b1;
        bus_if.sel_fcu   = 2'b01;
        bus_if.sel_eu    = 2'b10;
        bus_if.ready_bus = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_f = model_pick(1'b1, 1'b1);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(bus_if.gnt_fcu || bus_if.gnt_eu) && w < 6);
            check("cont_grant", bus_if.gnt_fcu | bus_if.gnt_eu, 1'b1);
            check("cont_winner_fcu", bus_if.gnt_fcu, exp_f);
            check("cont_sel", bus_if.sel_biu, exp_f ? 2'b01 : 2'b10);
        end
        drive_idle();
        wait_idle(1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_fcu", bus_if.gnt_fcu, 1'b0);
        check("rst_gnt_eu", bus_if.gnt_eu, 1'b0);
        check("rst_cs", bus_if.cs_biu, 1'b0);
        check("rst_sel", bus_if.sel_biu, 2'b00);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_pulses", {bus_if.done_fcu, bus_if.done_eu, bus_if.timeout}, 3'b000);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        for (int t = 0; t < 60; t++) run_txn();
        wait_idle(1'b0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);
        reset_mid_grant();
        continuous_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of cycles a grant may wait for ready_bus (range 1..15).
REQ-002 The block SHALL have parameter STARVE_LIM, default 4, meaning the number of consecutive lost arbitrations after which fcu is forced to win (range 1..7).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_fcu  input  1  fetch control unit bus request; level, held until done_fcu.
REQ-006 req_eu  input  1  execution unit bus request; level, held until done_eu.
REQ-007 sel_fcu  input  2  biu operation select supplied by fcu.
REQ-008 sel_eu  input  2  biu operation select supplied by eu.
REQ-009 ready_bus  input  1  biu transfer-complete pulse.
REQ-010 gnt_fcu, gnt_eu  output  1 each  grant to the requester; never both high.
REQ-011 cs_biu  output  1  biu chip select; high exactly while a grant is high.
REQ-012 sel_biu  output  2  operation select forwarded to the biu.
REQ-013 done_fcu, done_eu  output  1 each  one-cycle completion pulses.
REQ-014 timeout  output  1  one-cycle pulse on a forced release.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, GNT_FCU, GNT_EU and TURN.
REQ-017 In IDLE with any request active, the FSM SHALL move to the winner's GNT state on the next edge; gnt and cs_biu SHALL therefore be high one cycle after the request is first sampled.
REQ-018 sel_biu SHALL be registered from the winner's sel input at grant entry and held constant for the whole grant; it SHALL be 2'b00 outside a grant.
REQ-019 In GNT_x with ready_bus high, the block SHALL pulse done_x for that cycle and drop gnt_x and cs_biu on the next edge, then enter TURN.
REQ-020 TURN SHALL last exactly one cycle with cs_biu low, then go to IDLE; back-to-back grants are therefore separated by at least one idle-bus cycle.
REQ-021 A 4-bit hold counter SHALL clear on grant entry and increment each GNT cycle without ready_bus; on reaching MAX_HOLD the block SHALL pulse timeout, suppress done, and enter TURN.
REQ-022 If ready_bus and the MAX_HOLD limit occur in the same cycle, ready_bus SHALL win: done pulses and timeout does not.
REQ-023 If the granted requester deasserts its req before ready_bus, the block SHALL abort: no done, no timeout, enter TURN on the next edge.
REQ-024 ready_bus SHALL be ignored in IDLE and TURN.
REQ-025 Default arbitration is fixed priority: eu wins a simultaneous request.
REQ-026 A 3-bit starvation counter SHALL increment each time fcu is requesting and loses; when it equals STARVE_LIM, fcu SHALL win the next decision; the counter SHALL clear whenever fcu is granted.

Reset
REQ-027 While reset is low, the FSM SHALL be in IDLE, all counters zero, the round-robin pointer pointing at eu, and every output 0.
REQ-028 A reset assertion mid-grant SHALL drop gnt and cs_biu immediately, without any done or timeout pulse.

Configuration
REQ-029 With BUS_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not granted last, and the starvation counter SHALL be omitted.
REQ-030 Without BUS_ARB_ROUND_ROBIN_EN, arbitration SHALL follow REQ-025 and REQ-026.

Verification
REQ-031 req_fcu=1 with sel_fcu=2'b01, then ready_bus on the 3rd grant cycle -> gnt_fcu and cs_biu high from the cycle after the request; sel_biu=01; a single done_fcu pulse; one TURN cycle; busy low afterwards.
REQ-032 req_eu and req_fcu held high continuously, ready_bus every grant cycle, default build -> the sequence EU,EU,EU,EU,FCU repeats (STARVE_LIM=4).
REQ-033 The same stimulus with BUS_ARB_ROUND_ROBIN_EN defined -> grants strictly alternate EU,FCU,EU,FCU.
REQ-034 req_eu=1 and ready_bus never asserted, MAX_HOLD=15 -> timeout pulses in the 15th grant cycle; no done_eu; cs_biu low in the following cycle.
REQ-035 ready_bus asserted in the same cycle the hold counter reaches MAX_HOLD -> done_eu pulses and timeout stays 0.
REQ-036 reset driven low in the 2nd grant cycle -> all outputs 0 asynchronously; after release, a still-high req is granted again one cycle later.
